ptos_idle_param: RTL and testbench

//   Parametrised parallel-to-serial converter for the PCIe physical-layer lane, successor to the fixed 8-bit IDLE serializer.

---
 rtl/ptos_idle_param.sv | 107 ++++++++++
 tb/tb_ptos_idle_param.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ptos_idle_param.sv
// Parallel-to-serial lane converter with IDLE insertion and a lock phase.
// Words are shifted out one bit per clk32f cycle. IDLE_WORD fills any slot with
// no data, and LOCK_COUNT idle words must complete before data is accepted.
module ptos_idle_param #(
  parameter int unsigned       WIDTH      = 8,
  parameter logic [WIDTH-1:0]  IDLE_WORD  = 8'hBC,
  parameter bit                MSB_FIRST  = 1'b1,
  parameter int unsigned       LOCK_COUNT = 4
) (
  input  logic             clk32f,
  input  logic             reset,
  input  logic             active,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_sync,
  output logic             link_up
);

  localparam int unsigned CntW  = $clog2(WIDTH);
  localparam int unsigned IdleW = $clog2(LOCK_COUNT + 1);

  localparam logic [CntW-1:0]  CntMax  = CntW'(WIDTH - 1);
  localparam logic [IdleW-1:0] IdleSat = IdleW'(LOCK_COUNT);
  localparam logic [IdleW-1:0] IdleGo  = IdleW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    StReset,
    StIdle,
    StActive
  } state_e;

  state_e           r_state,    w_state_next;
  logic [WIDTH-1:0] r_sr,       w_sr_next;
  logic [CntW-1:0]  r_cnt,      w_cnt_next;
  logic [IdleW-1:0] r_idle_cnt, w_idle_cnt_next;
  logic             w_load;

  // State, shift register, bit index and lock counter; reset aborts any word in flight.
  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      r_state    <= StReset;
      r_sr       <= '0;
      r_cnt      <= CntMax;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_sr       <= w_sr_next;
      r_cnt      <= w_cnt_next;
      r_idle_cnt <= w_idle_cnt_next;
    end
  end

  // Next-state logic: shift every cycle, reload and step the FSM only on load edges.
  always_comb begin
    w_load          = (r_cnt == CntMax);
    w_state_next    = r_state;
    w_idle_cnt_next = r_idle_cnt;
    w_cnt_next      = w_load ? '0 : r_cnt + CntW'(1);

    if (MSB_FIRST) begin
      w_sr_next = {r_sr[WIDTH-2:0], 1'b0};
    end else begin
      w_sr_next = {1'b0, r_sr[WIDTH-1:1]};
    end

    if (w_load) begin
      // in_ready is high on every ACTIVE load edge, so an offered word is always
      // consumed here, even on the edge where active drops; it is never discarded.
      w_sr_next = (r_state == StActive && in_valid) ? in_data : IDLE_WORD;

      unique case (r_state)
        StReset: begin
          w_state_next = StIdle;
        end
        StIdle: begin
          if (active && (r_idle_cnt >= IdleGo)) begin
            w_state_next = StActive;
          end
          // Saturate so long idle periods cannot wrap the counter.
          if (r_idle_cnt != IdleSat) begin
            w_idle_cnt_next = r_idle_cnt + IdleW'(1);
          end
        end
        StActive: begin
          if (!active) begin
            w_state_next    = StIdle;
            w_idle_cnt_next = '0;
          end
        end
        default: begin
          w_state_next = StReset;
        end
      endcase
    end
  end

  // Outputs: serial bit straight from the register, plus framing and handshake flags.
  always_comb begin
    out      = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
    out_sync = (r_cnt == '0) && (r_state != StReset);
    link_up  = (r_state == StActive);
    in_ready = (r_state == StActive) && w_load;
  end

endmodule

// File: tb/tb_ptos_idle_param.sv
// Bench for ptos_idle_param: an MSB-first and an LSB-first instance share stimulus
// and are compared each cycle against a word-level model of the lane.
module tb_ptos_idle_param;

  localparam int unsigned W    = 8;
  localparam logic [7:0]  IDLE = 8'hBC;
  localparam int unsigned LOCK = 4;

  logic       clk32f = 1'b0;
  logic       reset;
  logic       active;
  logic       in_valid;
  logic [7:0] in_data;

  logic ready_m, out_m, sync_m, link_m;
  logic ready_l, out_l, sync_l, link_l;

  always #5 clk32f = ~clk32f;

  ptos_idle_param #(
    .WIDTH      (W),
    .IDLE_WORD  (IDLE),
    .MSB_FIRST  (1'b1),
    .LOCK_COUNT (LOCK)
  ) dut_msb (
    .clk32f   (clk32f),
    .reset    (reset),
    .active   (active),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (ready_m),
    .out      (out_m),
    .out_sync (sync_m),
    .link_up  (link_m)
  );

  ptos_idle_param #(
    .WIDTH      (W),
    .IDLE_WORD  (IDLE),
    .MSB_FIRST  (1'b0),
    .LOCK_COUNT (LOCK)
  ) dut_lsb (
    .clk32f   (clk32f),
    .reset    (reset),
    .active   (active),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (ready_l),
    .out      (out_l),
    .out_sync (sync_l),
    .link_up  (link_l)
  );

  int n_checks;
  int n_errors;

  // Word-level model: which word is on the wire, how far into it we are, and lock progress.
  bit         m_started;   // a first word has been launched since reset
  bit         m_link;
  int         m_done;      // idle words completed in the current lock attempt
  int         m_phase;     // bit position within the current word, 0 = first bit
  logic [7:0] m_word;

  // Driver state.
  logic [7:0] q_words[$];
  bit         q_gap[$];
  int         hold_edges;
  bit         pending_acc;
  int         act_off;
  int         rst_low;
  bit         gen_on;
  bit         rand_on;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_link    = 1'b0;
    m_done    = 0;
    m_phase   = W - 1;
    m_word    = '0;
  endtask

  function automatic bit exp_bit(input bit msb_first);
    if (!m_started) return 1'b0;
    return msb_first ? m_word[W-1-m_phase] : m_word[m_phase];
  endfunction

  task automatic check_outputs();
    check("out_msb",   out_m,   exp_bit(1'b1));
    check("out_lsb",   out_l,   exp_bit(1'b0));
    check("sync_msb",  sync_m,  m_started && m_phase == 0);
    check("sync_lsb",  sync_l,  m_started && m_phase == 0);
    check("link_msb",  link_m,  m_link);
    check("link_lsb",  link_l,  m_link);
    check("ready_msb", ready_m, m_link && m_phase == W - 1);
    check("ready_lsb", ready_l, m_link && m_phase == W - 1);
  endtask

  // Predict the effect of the coming clock edge given the inputs now applied.
  task automatic model_edge(output bit accepted, output bit idle_gap);
    accepted = 1'b0;
    idle_gap = 1'b0;
    if (!reset) return;
    if (m_phase != W - 1) begin
      m_phase++;
      return;
    end
    m_phase = 0;
    if (!m_started) begin
      m_started = 1'b1;
      m_word    = IDLE;
    end else if (m_link) begin
      if (in_valid) begin
        m_word   = in_data;
        accepted = 1'b1;
      end else begin
        m_word   = IDLE;
        idle_gap = 1'b1;
      end
      if (!active) begin
        m_link = 1'b0;
        m_done = 0;
      end
    end else begin
      m_word = IDLE;
      m_done++;
      if (active && m_done >= LOCK) m_link = 1'b1;
    end
  endtask

  // One clock cycle: drive at the falling edge, predict, then check at the next falling edge.
  task automatic cycle();
    bit acc;
    bit gap;
    if (pending_acc) begin
      in_valid    = 1'b0;
      pending_acc = 1'b0;
    end

    if (rst_low > 0) begin
      rst_low--;
      if (rst_low == 0) reset = 1'b1;
    end else if (rand_on && $urandom_range(0, 599) == 0) begin
      reset = 1'b0;
      model_reset();
      #1;
      check("rst_async_out", out_m, 0);
      check_outputs();
      rst_low = $urandom_range(1, 3);
    end

    if (act_off > 0) begin
      act_off--;
      if (act_off == 0) active = 1'b1;
    end else if (rand_on && !in_valid && $urandom_range(0, 249) == 0) begin
      active  = 1'b0;
      act_off = $urandom_range(3, 80);
    end

    if (gen_on && q_words.size() == 0) begin
      q_words.push_back(8'($urandom));
      q_gap.push_back($urandom_range(0, 3) == 0);
    end

    if (!in_valid && active && q_words.size() > 0 && hold_edges == 0) begin
      if (q_gap[0]) begin
        q_gap[0]   = 1'b0;
        hold_edges = 1;
      end else begin
        in_valid = 1'b1;
        in_data  = q_words.pop_front();
        void'(q_gap.pop_front());
      end
    end
    if (!in_valid) in_data = 8'($urandom);

    model_edge(acc, gap);
    pending_acc = acc;
    if (gap && hold_edges > 0) hold_edges--;
    @(negedge clk32f);
    check_outputs();
  endtask

  initial begin
    int first_link;
    int first_ready;
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b0;
    active      = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    hold_edges  = 0;
    pending_acc = 1'b0;
    act_off     = 0;
    rst_low     = 0;
    gen_on      = 1'b0;
    rand_on     = 1'b0;
    model_reset();

    // Reset held low for 20 cycles: everything quiet.
    repeat (20) begin
      @(negedge clk32f);
      check_outputs();
    end
    check("rst_link", link_m, 0);
    check("rst_ready", ready_m, 0);

    // Release with active already high: lock after four complete idle words.
    reset       = 1'b1;
    active      = 1'b1;
    first_link  = -1;
    first_ready = -1;
    for (int c = 1; c <= 48; c++) begin
      cycle();
      if (first_link < 0 && link_m) first_link = c;
      if (first_ready < 0 && ready_m) first_ready = c;
    end
    check("lock_edge", first_link, 33);
    check("first_ready", first_ready, 40);

    // Directed words: back-to-back pair, then one idle slot between 0x11 and 0x22.
    q_words.push_back(8'hA5); q_gap.push_back(1'b0);
    q_words.push_back(8'h3C); q_gap.push_back(1'b0);
    q_words.push_back(8'h11); q_gap.push_back(1'b0);
    q_words.push_back(8'h22); q_gap.push_back(1'b1);
    repeat (80) cycle();

    // Randomized traffic with active drops and mid-word reset pulses.
    gen_on  = 1'b1;
    rand_on = 1'b1;
    repeat (4000) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
